// File: rtl/alu_mdu_pkg.sv
// Shared types and helpers for the alu_mdu execute unit.
// Contents: default operand width, op-code enum, FSM state enum,
// is_div()/is_mul() op-class helpers.
package alu_mdu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned OP_W         = 5;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    MDU_MUL    = 5'd10,
    MDU_MULH   = 5'd11,
    MDU_MULHSU = 5'd12,
    MDU_MULHU  = 5'd13,
    MDU_DIV    = 5'd14,
    MDU_DIVU   = 5'd15,
    MDU_REM    = 5'd16,
    MDU_REMU   = 5'd17
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Divide/remainder family
  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
  endfunction

  // Multiply family
  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_MULHU);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Handshake bus of the alu_mdu execute unit.
// Request side : in_valid, in_ready, op, a, b
// Response side: out_valid, out_ready, result, busy
// master = operand source / result consumer, slave = alu_mdu.
interface alu_mdu_if
  import alu_mdu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/mdu_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// The first iteration runs on the start edge and the sign fix-up is folded
// into the last iteration, so done pulses XLEN cycles after start.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    load operands (pulse)
//   dividend, divisor        operands, read only while start is high
//   is_signed                treat operands as two's complement
//   done                     one-cycle pulse, quotient/remainder valid
//   quotient, remainder      results (sign-corrected when is_signed)
module mdu_divider
  import alu_mdu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic            neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic            active_q, active_d, done_q, done_d;
  logic [SHW-1:0]  cnt_q, cnt_d;

  logic [XLEN-1:0] s_rem, s_quo, s_dvs, n_rem, n_quo;
  logic [XLEN:0]   rem_sh, diff;

  // One restoring step; on start it works on the fresh operand magnitudes
  always_comb begin
    s_rem = rem_q;
    s_quo = quo_q;
    s_dvs = dvs_q;
    if (start) begin
      s_rem = '0;
      s_quo = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
      s_dvs = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
    end
    rem_sh = {s_rem, s_quo[XLEN-1]};
    diff   = rem_sh - {1'b0, s_dvs};
    if (diff[XLEN]) begin
      n_rem = rem_sh[XLEN-1:0];
      n_quo = {s_quo[XLEN-2:0], 1'b0};
    end else begin
      n_rem = diff[XLEN-1:0];
      n_quo = {s_quo[XLEN-2:0], 1'b1};
    end
  end

  // Next-state: iteration count, sign fix-up on the final step
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    if (start) begin
      rem_d     = n_rem;
      quo_d     = n_quo;
      dvs_d     = s_dvs;
      neg_quo_d = is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
      neg_rem_d = is_signed && dividend[XLEN-1];
      cnt_d     = SHW'(1);
      active_d  = 1'b1;
    end else if (active_q) begin
      cnt_d = cnt_q + SHW'(1);
      if (cnt_q == SHW'(XLEN - 1)) begin
        rem_d    = neg_rem_q ? -n_rem : n_rem;
        quo_d    = neg_quo_q ? -n_quo : n_quo;
        done_d   = 1'b1;
        active_d = 1'b0;
      end else begin
        rem_d = n_rem;
        quo_d = n_quo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      active_q  <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_mdu.sv
// Multi-cycle RV32I ALU + RV32M multiply/divide execute unit, one op in flight.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        alu_mdu_if.slave: in_valid/in_ready/op/a/b request,
//              out_valid/out_ready/result response, busy (CALC or DONE)
// Build option: ALU_MDU_FAST_MUL_EN selects a single-cycle multiplier;
// without it the MUL family runs an XLEN-cycle shift-add in CALC.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  alu_mdu_if.slave  bus
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic [OP_W-1:0] op_q, op_d;

  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic            div_start, div_signed, div_done;
  logic [XLEN-1:0] div_quo, div_rem;
  logic            mul_sa, mul_sb;

  assign shamt      = bus.b[SHW-1:0];
  assign div_signed = (bus.op == MDU_DIV) || (bus.op == MDU_REM);
  assign mul_sa     = (bus.op == MDU_MULH) || (bus.op == MDU_MULHSU);
  assign mul_sb     = (bus.op == MDU_MULH);

  // Single-cycle ALU ops; illegal codes give 0
  always_comb begin
    alu_res = '0;
    case (bus.op)
      ALU_ADD:  alu_res = bus.a + bus.b;
      ALU_SUB:  alu_res = bus.a - bus.b;
      ALU_AND:  alu_res = bus.a & bus.b;
      ALU_OR:   alu_res = bus.a | bus.b;
      ALU_XOR:  alu_res = bus.a ^ bus.b;
      ALU_SLL:  alu_res = bus.a << shamt;
      ALU_SRL:  alu_res = bus.a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(bus.a) >>> shamt);
      ALU_SLT:  alu_res = XLEN'($signed(bus.a) < $signed(bus.b));
      ALU_SLTU: alu_res = XLEN'(bus.a < bus.b);
      default:  alu_res = '0;
    endcase
  end

`ifdef ALU_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;

  // Sign/zero extension to 2*XLEN makes one truncated product serve all four ops
  always_comb begin
    mul_a_ext = {{XLEN{mul_sa & bus.a[XLEN-1]}}, bus.a};
    mul_b_ext = {{XLEN{mul_sb & bus.b[XLEN-1]}}, bus.b};
    mul_prod  = mul_a_ext * mul_b_ext;
  end
`else
  logic [2*XLEN-1:0] mcand_q, mcand_d, prod_q, prod_d, prod_step, prod_fix;
  logic [XLEN-1:0]   mplier_q, mplier_d, mag_a, mag_b;
  logic              mneg_q, mneg_d;
  logic [SHW-1:0]    cnt_q, cnt_d;

  assign mag_a = (mul_sa && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign mag_b = (mul_sb && bus.b[XLEN-1]) ? -bus.b : bus.b;
`endif

  mdu_divider #(
    .XLEN(XLEN)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .is_signed (div_signed),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Next-state and registered-output values
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    op_d      = op_q;
    div_start = 1'b0;
`ifndef ALU_MDU_FAST_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    mneg_d    = mneg_q;
    cnt_d     = cnt_q;
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    prod_fix  = mneg_q ? -prod_step : prod_step;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.op;
          if (is_div(bus.op)) begin
            // Zero divisor and signed overflow need no iteration
            if (bus.b == '0) begin
              result_d = ((bus.op == MDU_DIV) || (bus.op == MDU_DIVU)) ? '1 : bus.a;
              state_d  = DONE;
            end else if (div_signed && (bus.a == MIN_VAL) && (bus.b == '1)) begin
              result_d = (bus.op == MDU_DIV) ? MIN_VAL : '0;
              state_d  = DONE;
            end else begin
              div_start = 1'b1;
              state_d   = CALC;
            end
          end else if (is_mul(bus.op)) begin
`ifdef ALU_MDU_FAST_MUL_EN
            result_d = (bus.op == MDU_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
            state_d  = DONE;
`else
            mcand_d  = {{XLEN{1'b0}}, mag_a};
            mplier_d = mag_b;
            prod_d   = '0;
            mneg_d   = (mul_sa & bus.a[XLEN-1]) ^ (mul_sb & bus.b[XLEN-1]);
            cnt_d    = '0;
            state_d  = CALC;
`endif
          end else begin
            result_d = alu_res;
            state_d  = DONE;
          end
        end
      end

      CALC: begin
        if (is_div(op_q)) begin
          if (div_done) begin
            result_d = ((op_q == MDU_DIV) || (op_q == MDU_DIVU)) ? div_quo : div_rem;
            state_d  = DONE;
          end
        end else begin
`ifndef ALU_MDU_FAST_MUL_EN
          // Shift-add on magnitudes; negate the full product on the last step
          prod_d   = prod_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SHW'(1);
          if (cnt_q == SHW'(XLEN - 1)) begin
            result_d = (op_q == MDU_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            state_d  = DONE;
          end
`endif
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      op_q        <= '0;
`ifndef ALU_MDU_FAST_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      mneg_q      <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      op_q        <= op_d;
`ifndef ALU_MDU_FAST_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      mneg_q      <= mneg_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;

endmodule
